// File: rtl/red_sched_if.sv
// ============================================================================
//  Module      : red_sched_if
//  Description : Bundles the two requester channels and the response channel
//                used by red_sched. The master side drives requests and
//                consumes responses. The slave side is the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface red_sched_if;
  // requester 0
  logic       req0_valid;
  logic [3:0] req0_data;
  logic [1:0] req0_op;
  logic       req0_ready;
  // requester 1
  logic       req1_valid;
  logic [3:0] req1_data;
  logic [1:0] req1_op;
  logic       req1_ready;
  // response
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic       rsp_result;

  modport master (
    output req0_valid, req0_data, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/red_sched.sv
// ============================================================================
//  Module      : red_sched
//  Description : Two-requester scheduler around one shared 4-input reduction
//                unit (AND / OR / XOR / NAND). IDLE grants and captures one
//                request, EXEC computes and registers the result, and RESP
//                presents it until the consumer accepts it. The latency is
//                fixed at two cycles from accept to rsp_valid.
//                Optional macro ROUND_ROBIN_EN selects round-robin
//                arbitration. Without it, requester 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  red_sched_if.slave       bus,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  logic [3:0]       r_data;
  logic [1:0]       r_op;
  logic             r_id;
  logic             r_result;
  logic [CNT_W-1:0] r_done;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any_valid;
  logic             w_accept;
  logic             w_rsp_fire;
  logic             w_red;

  assign w_any_valid = bus.req0_valid | bus.req1_valid;
  assign w_accept    = (r_state == ST_IDLE) && w_any_valid;
  assign w_rsp_fire  = (r_state == ST_RESP) && bus.rsp_ready;

`ifdef ROUND_ROBIN_EN
  // r_ptr = 0 favours requester 0 and r_ptr = 1 favours requester 1.
  logic r_ptr;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_gnt0 = ~r_ptr;
      w_gnt1 = r_ptr;
    end else begin
      w_gnt0 = bus.req0_valid;
      w_gnt1 = bus.req1_valid;
    end
  end

  // Pointer moves only when the response is handed off, towards the other requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_rsp_fire) begin
      r_ptr <= ~r_id;
    end
  end
`else
  // Fixed-priority grant: requester 0 always wins on contention.
  always_comb begin
    w_gnt0 = bus.req0_valid;
    w_gnt1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // The single shared reduction unit, fed only from the captured operand.
  always_comb begin
    w_red = 1'b0;
    case (r_op)
      OP_AND:  w_red = &r_data;
      OP_OR:   w_red = |r_data;
      OP_XOR:  w_red = ^r_data;
      default: w_red = ~(&r_data);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_valid) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: grants only in IDLE and never during reset. rsp_valid is high only in RESP.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_gnt0 & ~reset;
        bus.req1_ready = w_gnt1 & ~reset;
      end
      ST_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the winner's operand, op and id on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= 4'd0;
      r_op   <= 2'd0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_gnt1 ? bus.req1_data : bus.req0_data;
      r_op   <= w_gnt1 ? bus.req1_op   : bus.req0_op;
      r_id   <= w_gnt1;
    end
  end

  // Register the reduction result in EXEC. It stays stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= w_red;
    end
  end

  // Completed-handshake counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= '0;
    end else if (w_rsp_fire && !(&r_done)) begin
      r_done <= r_done + CNT_ONE;
    end
  end

  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
  assign done_count     = r_done;

endmodule

`default_nettype wire
